// File: rtl/freq_meter_if.sv
// Signal bundle between the strobe source and the period meter.
// The master drives the strobe; the slave (the meter) returns the measurement results.
interface freq_meter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 SIG_IN;
    logic [CNT_WIDTH-1:0] PERIOD;
    logic                 PERIOD_VALID;
    logic                 LOCKED;
    logic                 TIMEOUT;

    modport master (
        output SIG_IN,
        input  PERIOD,
        input  PERIOD_VALID,
        input  LOCKED,
        input  TIMEOUT
    );

    modport slave (
        input  SIG_IN,
        output PERIOD,
        output PERIOD_VALID,
        output LOCKED,
        output TIMEOUT
    );
endinterface

// File: rtl/freq_meter.sv
// Period meter for a slow asynchronous strobe: synchronises it into CLK, measures the
// rising-edge spacing in CLK cycles, and reports lock and loss of signal.
module freq_meter #(
    parameter int CNT_WIDTH       = 16,
    parameter int EXPECTED_PERIOD = 4,
    parameter int TOLERANCE       = 0,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    freq_meter_if.slave   bus
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int DIFF_W = CNT_WIDTH + 1;

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_sync;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  w_count_next;
    logic [CNT_WIDTH-1:0]  r_period;
    logic [CNT_WIDTH-1:0]  w_period_next;
    logic                  r_valid;
    logic                  w_valid_next;
    logic                  r_locked;
    logic                  w_locked_next;
    logic                  r_timeout;
    logic                  w_timeout_next;
    logic [GOOD_W-1:0]     r_good;
    logic [GOOD_W-1:0]     w_good_next;
    logic [GOOD_W-1:0]     w_good_sat;
    logic                  w_edge;
    logic                  w_good;
    logic                  w_at_timeout;
    logic [DIFF_W-1:0]     w_meas;
    logic [DIFF_W-1:0]     w_exp;
    logic [DIFF_W-1:0]     w_diff;

    // Three-flop chain: two stages of metastability settling plus one for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync[0] <= 1'b0;
        end else begin
            r_sync[0] <= bus.SIG_IN;
        end
    end

    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_sync
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_edge = r_sync[1] & ~r_sync[2];

    // Distance from nominal, widened by one bit so the subtraction can never wrap.
    assign w_meas       = {1'b0, r_count};
    assign w_exp        = DIFF_W'(EXPECTED_PERIOD);
    assign w_diff       = (w_meas >= w_exp) ? (w_meas - w_exp) : (w_exp - w_meas);
    assign w_good       = (w_diff <= DIFF_W'(TOLERANCE));
    assign w_good_sat   = (r_good >= GOOD_W'(LOCK_COUNT)) ? GOOD_W'(LOCK_COUNT)
                                                           : (r_good + GOOD_W'(1));
    assign w_at_timeout = (r_count == CNT_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_period_next  = r_period;
        w_valid_next   = 1'b0;
        w_locked_next  = r_locked;
        w_timeout_next = r_timeout;
        w_good_next    = r_good;
        case (r_state)
            ST_IDLE: begin
                w_count_next = '0;
                if (w_edge) begin
                    w_count_next   = CNT_WIDTH'(1);
                    w_timeout_next = 1'b0;
                    w_state_next   = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // An edge arriving on the timeout cycle still counts as a valid period.
                if (w_edge) begin
                    w_period_next = r_count;
                    w_valid_next  = 1'b1;
                    w_count_next  = CNT_WIDTH'(1);
                    if (w_good) begin
                        w_good_next   = w_good_sat;
                        w_locked_next = (w_good_sat == GOOD_W'(LOCK_COUNT));
                    end else begin
                        w_good_next   = '0;
                        w_locked_next = 1'b0;
                    end
                end else if (w_at_timeout) begin
                    w_timeout_next = 1'b1;
                    w_locked_next  = 1'b0;
                    w_good_next    = '0;
                    w_count_next   = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_count_next = r_count + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
            r_good    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_period  <= w_period_next;
            r_valid   <= w_valid_next;
            r_locked  <= w_locked_next;
            r_timeout <= w_timeout_next;
            r_good    <= w_good_next;
        end
    end

    assign bus.PERIOD       = r_period;
    assign bus.PERIOD_VALID = r_valid;
    assign bus.LOCKED       = r_locked;
    assign bus.TIMEOUT      = r_timeout;
endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three instances (defaults, TOLERANCE=1, TIMEOUT_CYCLES=8) driven by
// per-rise stimulus rows; each expected PERIOD_VALID is queued with its due cycle.
module tb_freq_meter;
    logic clk;
    logic rst_a, rst_b, rst_c;

    freq_meter_if #(.CNT_WIDTH(16)) if_a ();
    freq_meter_if #(.CNT_WIDTH(16)) if_b ();
    freq_meter_if #(.CNT_WIDTH(16)) if_c ();

    freq_meter #(.CNT_WIDTH(16), .EXPECTED_PERIOD(4), .TOLERANCE(0), .LOCK_COUNT(4),
                 .TIMEOUT_CYCLES(1024))
        u_a (.CLK(clk), .RST(rst_a), .bus(if_a));
    freq_meter #(.CNT_WIDTH(16), .EXPECTED_PERIOD(4), .TOLERANCE(1), .LOCK_COUNT(4),
                 .TIMEOUT_CYCLES(1024))
        u_b (.CLK(clk), .RST(rst_b), .bus(if_b));
    freq_meter #(.CNT_WIDTH(16), .EXPECTED_PERIOD(4), .TOLERANCE(0), .LOCK_COUNT(4),
                 .TIMEOUT_CYCLES(8))
        u_c (.CLK(clk), .RST(rst_c), .bus(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int dut;
        int due;
        int period;
        bit locked;
    } exp_t;

    typedef struct {
        int dut;
        int len;
        bit v;
        int period;
        bit locked;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[0:15];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   c_watch = 1'b0;
    int   last_rise = 0;

    task automatic chk(input string name, input int d, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0d expected=%0d", name, d, cyc, act, exp_v);
        end
    endtask

    task automatic monitor(input int d, input logic v, input logic [15:0] p,
                           input logic l, input logic t);
        int found;
        exp_t e;
        if (v) begin
            found = -1;
            for (int i = 0; i < sb.size(); i++)
                if (found < 0 && sb[i].dut == d) found = i;
            if (found < 0) begin
                chk("unexpected_valid", d, 1, 0);
            end else begin
                e = sb[found];
                sb.delete(found);
                chk("valid_cycle", d, cyc, e.due);
                chk("period", d, int'(p), e.period);
                chk("locked", d, int'(l), int'(e.locked));
                chk("timeout_at_valid", d, int'(t), 0);
                $display("txn dut%0d cyc=%0d period=%0d locked=%0b", d, cyc, p, l);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor(0, if_a.PERIOD_VALID, if_a.PERIOD, if_a.LOCKED, if_a.TIMEOUT);
        monitor(1, if_b.PERIOD_VALID, if_b.PERIOD, if_b.LOCKED, if_b.TIMEOUT);
        monitor(2, if_c.PERIOD_VALID, if_c.PERIOD, if_c.LOCKED, if_c.TIMEOUT);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due < cyc) begin
                chk("missing_valid", sb[i].dut, 0, 1);
                sb.delete(i);
            end
        end
        if (c_watch) chk("c_no_timeout", 2, int'(if_c.TIMEOUT), 0);
    endtask

    task automatic set_sig(input int d, input logic v);
        case (d)
            0: if_a.SIG_IN = v;
            1: if_b.SIG_IN = v;
            default: if_c.SIG_IN = v;
        endcase
    endtask

    // One strobe period: rise now, fall after len/2 cycles, next rise len cycles later.
    task automatic drive_rise(input int d, input int len, input bit v, input int p, input bit l);
        exp_t e;
        set_sig(d, 1'b1);
        last_rise = cyc;
        if (v) begin
            e.dut = d;
            e.due = cyc + 3;
            e.period = p;
            e.locked = l;
            sb.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            tick();
            if (i + 1 == len / 2) set_sig(d, 1'b0);
        end
    endtask

    task automatic chk_zero(input int d, input logic [15:0] p, input logic v,
                            input logic l, input logic t);
        chk("rst_period", d, int'(p), 0);
        chk("rst_valid", d, int'(v), 0);
        chk("rst_locked", d, int'(l), 0);
        chk("rst_timeout", d, int'(t), 0);
    endtask

    initial begin
        // dut, len, valid, period, locked
        vecs[0]  = '{0, 4, 1'b0, 0, 1'b0};
        vecs[1]  = '{0, 4, 1'b1, 4, 1'b0};
        vecs[2]  = '{0, 4, 1'b1, 4, 1'b0};
        vecs[3]  = '{0, 4, 1'b1, 4, 1'b0};
        vecs[4]  = '{0, 6, 1'b1, 4, 1'b1};
        vecs[5]  = '{0, 4, 1'b1, 6, 1'b0};
        vecs[6]  = '{0, 4, 1'b1, 4, 1'b0};
        vecs[7]  = '{0, 4, 1'b1, 4, 1'b0};
        vecs[8]  = '{0, 4, 1'b1, 4, 1'b0};
        vecs[9]  = '{0, 4, 1'b1, 4, 1'b1};
        vecs[10] = '{1, 3, 1'b0, 0, 1'b0};
        vecs[11] = '{1, 5, 1'b1, 3, 1'b0};
        vecs[12] = '{1, 4, 1'b1, 5, 1'b0};
        vecs[13] = '{1, 4, 1'b1, 4, 1'b0};
        vecs[14] = '{1, 6, 1'b1, 4, 1'b1};
        vecs[15] = '{1, 4, 1'b1, 6, 1'b0};

        if_a.SIG_IN = 1'b0;
        if_b.SIG_IN = 1'b0;
        if_c.SIG_IN = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        repeat (10) tick();
        chk_zero(0, if_a.PERIOD, if_a.PERIOD_VALID, if_a.LOCKED, if_a.TIMEOUT);
        chk_zero(1, if_b.PERIOD, if_b.PERIOD_VALID, if_b.LOCKED, if_b.TIMEOUT);
        chk_zero(2, if_c.PERIOD, if_c.PERIOD_VALID, if_c.LOCKED, if_c.TIMEOUT);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Default instance: lock, stretched period, relock.
        for (int i = 0; i <= 9; i++)
            drive_rise(vecs[i].dut, vecs[i].len, vecs[i].v, vecs[i].period, vecs[i].locked);

        // Loss of signal: TIMEOUT appears exactly 1027 sampling cycles after the last rise drive.
        while (cyc < last_rise + 1026) tick();
        chk("pre_timeout", 0, int'(if_a.TIMEOUT), 0);
        chk("pre_timeout_locked", 0, int'(if_a.LOCKED), 1);
        tick();
        chk("timeout", 0, int'(if_a.TIMEOUT), 1);
        chk("timeout_locked", 0, int'(if_a.LOCKED), 0);

        // Recovery rise clears TIMEOUT without a measurement.
        set_sig(0, 1'b1);
        tick();
        tick();
        chk("timeout_held", 0, int'(if_a.TIMEOUT), 1);
        set_sig(0, 1'b0);
        tick();
        chk("timeout_cleared", 0, int'(if_a.TIMEOUT), 0);
        tick();
        drive_rise(0, 5, 1'b1, 4, 1'b0);

        // Reset mid-period discards the partial count.
        rst_a = 1'b1;
        tick();
        chk_zero(0, if_a.PERIOD, if_a.PERIOD_VALID, if_a.LOCKED, if_a.TIMEOUT);
        rst_a = 1'b0;
        drive_rise(0, 4, 1'b0, 0, 1'b0);
        drive_rise(0, 4, 1'b1, 4, 1'b0);
        repeat (4) tick();

        // Tolerance instance.
        for (int i = 10; i <= 15; i++)
            drive_rise(vecs[i].dut, vecs[i].len, vecs[i].v, vecs[i].period, vecs[i].locked);
        repeat (4) tick();

        // Short-timeout instance: edges land exactly on the timeout cycle.
        c_watch = 1'b1;
        drive_rise(2, 8, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) drive_rise(2, 8, 1'b1, 8, 1'b0);
        drive_rise(2, 8, 1'b1, 8, 1'b0);
        c_watch = 1'b0;
        while (cyc < last_rise + 10) tick();
        chk("c_pre_timeout", 2, int'(if_c.TIMEOUT), 0);
        tick();
        chk("c_timeout", 2, int'(if_c.TIMEOUT), 1);

        repeat (6) tick();
        chk("scoreboard_empty", -1, sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Receiver-side counterpart to the clock divider.
- Takes a slow, asynchronous periodic strobe (for example a divided ADC sample clock) and synchronises it into the CLK domain.
- Measures the rising-edge-to-rising-edge period in CLK cycles.
- Reports each period with a valid pulse, flags loss of signal, and declares lock once the period repeatedly matches an expected value. Used by the ADC timing logic to confirm the sampling strobe before PMU acquisition starts.

Parameters:
- CNT_WIDTH, 16, width of the period counter and of PERIOD.
- EXPECTED_PERIOD, 4, nominal period in CLK cycles.
- TOLERANCE, 0, maximum allowed |PERIOD - EXPECTED_PERIOD| for a measurement to count as good.
- LOCK_COUNT, 4, number of consecutive good measurements required for LOCKED.
- TIMEOUT_CYCLES, 1024, CLK cycles without an edge before loss of signal is declared. Legal range is 2 to 2^CNT_WIDTH-1.

Ports:
- CLK, input, 1, system clock (32.768 MHz).
- RST, input, 1, synchronous active-high reset.
- SIG_IN, input, 1, asynchronous strobe to be measured.
- PERIOD, output, CNT_WIDTH, last measured period in CLK cycles.
- PERIOD_VALID, output, 1, one-cycle pulse when PERIOD updates.
- LOCKED, output, 1, period stable within tolerance.
- TIMEOUT, output, 1, no edge for TIMEOUT_CYCLES; sticky until the next edge.

Behaviour:
- Reset: RST is sampled on the CLK rising edge only.
  - While RST=1, the next edge clears PERIOD, PERIOD_VALID, LOCKED, TIMEOUT, the counter, the good-run counter and all three synchroniser/edge flops (s1, s2, s3), and sets state to IDLE.
  - Reset mid-measurement discards the partial count; no PERIOD_VALID is emitted.
- Synchroniser: s1 <= SIG_IN, s2 <= s1, s3 <= s2.
  - Edge event E = s2 & ~s3.
  - A SIG_IN rise sampled at CLK edge k gives E high in cycle k+2 (cycle "e").
  - SIG_IN held high through reset produces one E after release; this is treated as a first edge.
- Minimum supported period is 2 CLK cycles; behaviour below that is undefined.
- State IDLE:
  - count is held at 0.
  - On E: count <= 1 and state -> MEASURE. No PERIOD_VALID is emitted.
  - TIMEOUT <= 0 on E.
- State MEASURE:
  - count increments by 1 per cycle, so count equals k in cycle e+k.
  - On E, when count equals N:
    - PERIOD <= N.
    - PERIOD_VALID = 1 in the following cycle only.
    - count <= 1.
    - The lock update is applied.
  - With no E and count == TIMEOUT_CYCLES:
    - TIMEOUT <= 1, LOCKED <= 0, good-run counter <= 0.
    - state -> IDLE, count <= 0.
    - PERIOD keeps its last value.
  - If E and the timeout condition coincide, E wins: PERIOD = TIMEOUT_CYCLES is reported and no timeout is declared.
- Lock update (same edge that loads PERIOD):
  - Good measurement (|N - EXPECTED_PERIOD| <= TOLERANCE, computed without wrap): good_cnt <= min(good_cnt+1, LOCK_COUNT).
  - LOCKED <= (new good_cnt == LOCK_COUNT).
  - Bad measurement: good_cnt <= 0 and LOCKED <= 0.
  - LOCKED therefore changes only in the same cycle PERIOD_VALID is high, or on timeout/reset.
- Counter never exceeds TIMEOUT_CYCLES, so no saturation logic is needed.
- Latency from a SIG_IN rising edge to PERIOD_VALID is 3 CLK cycles.

Test Plan:
- Defaults; RST high 10 cycles, then SIG_IN 2 high/2 low.
  - First PERIOD_VALID comes 3 cycles after the second SIG_IN rise, with PERIOD=4.
  - PERIOD_VALID then pulses every 4 cycles.
  - LOCKED rises with the 4th PERIOD_VALID.
- After lock, one SIG_IN period stretched to 6 cycles.
  - PERIOD=6.
  - LOCKED falls in the same cycle as that PERIOD_VALID.
  - LOCKED re-asserts on the 4th subsequent period-4 measurement.
- SIG_IN held low after lock.
  - TIMEOUT=1 and LOCKED=0, 1025 cycles after the last E.
  - The next rise clears TIMEOUT with no PERIOD_VALID.
  - The rise after that reports the correct period.
- TOLERANCE=1, periods 3,5,4,4.
  - LOCKED after the 4th valid measurement.
  - A following period of 6 drops LOCKED.
- RST pulsed for 1 cycle midway through a period.
  - All outputs are 0 the cycle after.
  - The first post-reset edge produces no PERIOD_VALID.
  - The second produces the correct PERIOD.
- TIMEOUT_CYCLES=8, edges exactly 8 cycles apart.
  - PERIOD=8 is reported each time.
  - TIMEOUT never asserts.
